// File: rtl/svnet_tree_mul_sched_pkg.sv
// Shared types and helpers for the tree-multiplier scheduler.
// Arbitration works on a fixed-width mask so one helper serves any NUM_REQ up to MAX_REQ.
package svnet_tree_mul_sched_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_TAG_W = 4;

    typedef logic [MAX_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic hit;
        tag_t idx;
    } pick_t;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // First set bit of mask at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] mask, input int n, input tag_t ptr);
        pick_t p;
        int    idx;
        p.hit = 1'b0;
        p.idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !p.hit && mask[idx[MAX_TAG_W-1:0]]) begin
                p.hit = 1'b1;
                p.idx = idx[MAX_TAG_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/svnet_tree_mul_sched_fifo.sv
// Per-requester result FIFO plus credit counter; output is registered (valid the cycle after push).
// Credit = free slots minus ops in flight, so the non-stallable return path can never overflow it.
module svnet_tree_mul_sched_fifo
    import svnet_tree_mul_sched_pkg::*;
#(
    parameter int DAT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             grant,
    output logic             credit_ok,
    input  logic             push,
    input  logic [DAT_W-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             rsp_vld,
    output logic [DAT_W-1:0] rsp_dat
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cred_w(DEPTH);

    logic [DEPTH-1:0][DAT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d, credit_q, credit_d;
    logic                        pop;

    always_comb begin
        pop   = (cnt_q != '0) && pop_rdy;
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        credit_d = credit_q - CNT_W'(grant) + CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            credit_q <= CNT_W'(DEPTH);
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign credit_ok = (credit_q != '0);
    assign rsp_vld   = (cnt_q != '0);
    assign rsp_dat   = mem_q[rd_q];

    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) push |-> (cnt_q != CNT_W'(DEPTH)));
    a_credit_max:    assert property (@(posedge clk) disable iff (!rst_n) credit_q <= CNT_W'(DEPTH));
    a_credit_under:  assert property (@(posedge clk) disable iff (!rst_n) grant |-> (credit_q != '0));

endmodule

// File: rtl/svnet_tree_mul_sched.sv
// Round-robin share of one fixed-latency multiplier among NUM_REQ requesters; request to o_rsp_valid is LATENCY+2 cycles.
// Requests are held off by per-requester credits; results wait in per-requester FIFOs until i_rsp_ready.
module svnet_tree_mul_sched
    import svnet_tree_mul_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int COUNT      = 4,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    output logic [NUM_REQ-1:0]                     o_req_ready,
    input  logic [NUM_REQ-1:0][COUNT-1:0][WIDTH-1:0] i_req_data,
    output logic                                   o_mul_valid,
    output logic [COUNT-1:0][WIDTH-1:0]            o_mul_data,
    input  logic                                   i_mul_valid,
    input  logic [COUNT*WIDTH-1:0]                 i_mul_data,
    output logic [NUM_REQ-1:0]                     o_rsp_valid,
    input  logic [NUM_REQ-1:0]                     i_rsp_ready,
    output logic [NUM_REQ-1:0][COUNT*WIDTH-1:0]    o_rsp_data,
    output logic                                   o_busy
);
    localparam int TAG_W  = tag_w(NUM_REQ);
    localparam int PROD_W = COUNT * WIDTH;
    localparam int FL_W   = $clog2(LATENCY + 2);

    logic [TAG_W-1:0]              ptr_q, ptr_d, gidx;
    logic [NUM_REQ-1:0]            credit_ok, grant;
    logic [MAX_REQ-1:0]            elig;
    pick_t                         pick;
    logic                          mul_vld_q, mul_vld_d;
    logic [COUNT-1:0][WIDTH-1:0]   mul_dat_q, mul_dat_d;
    logic [LATENCY:0]              tag_vld_q, tag_vld_d;
    logic [LATENCY:0][TAG_W-1:0]   tag_q, tag_d;
    logic [FL_W-1:0]               flush_q, flush_d;
    logic                          ret_vld;
    logic [TAG_W-1:0]              ret_tag;

    always_comb begin
        elig                = '0;
        elig[NUM_REQ-1:0]   = i_req_valid & credit_ok;
        pick                = rr_pick(elig, NUM_REQ, tag_t'(ptr_q));
        grant               = '0;
        gidx                = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rst_n && pick.hit && pick.idx == tag_t'(r)) begin
                grant[r] = 1'b1;
                gidx     = TAG_W'(r);
            end
        end
        ptr_d     = ptr_q;
        mul_dat_d = mul_dat_q;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                mul_dat_d = i_req_data[r];
                ptr_d     = (r == NUM_REQ - 1) ? '0 : TAG_W'(r + 1);
            end
        end
        mul_vld_d = |grant;
        // Tag stage 0 lines up with o_mul_valid; stage LATENCY lines up with i_mul_valid.
        tag_vld_d = {tag_vld_q[LATENCY-1:0], |grant};
        tag_d     = {tag_q[LATENCY-1:0], gidx};
        flush_d   = (flush_q != '0) ? flush_q - 1'b1 : flush_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            mul_vld_q <= 1'b0;
            mul_dat_q <= '0;
            tag_vld_q <= '0;
            tag_q     <= '0;
            flush_q   <= FL_W'(LATENCY + 1);
        end else begin
            ptr_q     <= ptr_d;
            mul_vld_q <= mul_vld_d;
            mul_dat_q <= mul_dat_d;
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
            flush_q   <= flush_d;
        end
    end

    // Results with no live tag are leftovers from before a reset and are dropped.
    assign ret_vld = i_mul_valid && tag_vld_q[LATENCY];
    assign ret_tag = tag_q[LATENCY];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
        svnet_tree_mul_sched_fifo #(
            .DAT_W (PROD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .grant     (grant[r]),
            .credit_ok (credit_ok[r]),
            .push      (ret_vld && (ret_tag == TAG_W'(r))),
            .push_dat  (i_mul_data),
            .pop_rdy   (i_rsp_ready[r]),
            .rsp_vld   (o_rsp_valid[r]),
            .rsp_dat   (o_rsp_data[r])
        );
    end

    assign o_req_ready = grant;
    assign o_mul_valid = mul_vld_q;
    assign o_mul_data  = mul_dat_q;
    assign o_busy      = (|tag_vld_q) || mul_vld_q || (|o_rsp_valid);

    // Stray multiplier outputs are tolerated only while pre-reset ops drain out.
    a_tag_align: assert property (@(posedge clk) disable iff (!rst_n)
                                  (flush_q == '0) |-> (i_mul_valid == tag_vld_q[LATENCY]));
    a_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_req_ready));

endmodule
